acc_proc_core: RTL and testbench

//  Parametrised accumulator processor core: N-bit datapath, 2**ADDR_W-entry

---
 rtl/acc_proc_core.sv | 267 ++++++++++++++++++++++++++
 tb/tb_acc_proc_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_proc_core.sv
// acc_proc_core: accumulator processor with serial imem/dmem frame loader,
// HALT, cycle counter, termination status and a debug read port.
//
// Optional feature: define ACC_PROC_WDOG_EN to enable the execute-cycle
// watchdog (limit WDOG_CYCLES, status WDOG). Default build has no limit.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   run_i             execute request (level)
//   cs_i_n, cs_d_n    imem / dmem load chip selects (active-low)
//   mosi_i            serial load data, MSB first
//   done_o            FSM is IDLE
//   status_o          0 NONE, 1 END, 2 HALT, 3 ABORT, 4 WDOG
//   cycles_o          executed-cycle count of the last/current run
//   frame_err_o       one-cycle pulse on a rejected load frame
//   acc_o             accumulator
//   dbg_sel_i         1 = read imem, 0 = read dmem
//   dbg_addr_i        debug read address
//   dbg_data_o        combinational debug read data (imem zero-extended)
module acc_proc_core #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int WDOG_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              cs_i_n,
    input  logic              cs_d_n,
    input  logic              mosi_i,
    output logic              done_o,
    output logic [2:0]        status_o,
    output logic [15:0]       cycles_o,
    output logic              frame_err_o,
    output logic [DATA_W-1:0] acc_o,
    input  logic              dbg_sel_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    localparam int INST_W  = ADDR_W + 4;
    localparam int FRAME_W = DATA_W + ADDR_W;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W-1:0] LAST_PC  = '1;
    localparam logic [15:0]       WDOG_LIM = 16'(WDOG_CYCLES);

`ifdef ACC_PROC_WDOG_EN
    localparam logic WDOG_EN = 1'b1;
`else
    localparam logic WDOG_EN = 1'b0;
`endif

    localparam logic [2:0] ST_NONE  = 3'd0;
    localparam logic [2:0] ST_END   = 3'd1;
    localparam logic [2:0] ST_HALT  = 3'd2;
    localparam logic [2:0] ST_ABORT = 3'd3;
    localparam logic [2:0] ST_WDOG  = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_MULL = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_MULH = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SRA  = 4'hB;
    localparam logic [3:0] OP_LDI  = 4'hC;
    localparam logic [3:0] OP_BEQZ = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_BNEZ = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_IRECV,
        S_DRECV
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [DATA_W-1:0]    acc_q, acc_d;
    logic [15:0]          cycles_q, cycles_d;
    logic [2:0]           status_q, status_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ferr_q, ferr_d;

    logic [INST_W-1:0]    imem_q [DEPTH];
    logic [DATA_W-1:0]    dmem_q [DEPTH];

    logic                 imem_we;
    logic                 dmem_we;
    logic [ADDR_W-1:0]    dmem_waddr;
    logic [DATA_W-1:0]    dmem_wdata;

    logic [INST_W-1:0]    inst;
    logic [3:0]           opcode;
    logic [ADDR_W-1:0]    operand;
    logic [DATA_W-1:0]    m_val;
    logic [DATA_W-1:0]    imm;
    logic signed [2*DATA_W-1:0] prod;
    logic                 cs_n;
    logic                 taken;
    logic                 wdog_hit;

    assign inst     = imem_q[pc_q];
    assign opcode   = inst[3:0];
    assign operand  = inst[INST_W-1:4];
    assign m_val    = dmem_q[operand];
    assign imm      = DATA_W'($signed(operand));
    assign prod     = (2*DATA_W)'($signed(acc_q)) * (2*DATA_W)'($signed(m_val));
    assign cs_n     = (state_q == S_IRECV) ? cs_i_n : cs_d_n;
    assign wdog_hit = WDOG_EN && (cycles_q == WDOG_LIM);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        cycles_d   = cycles_q;
        status_d   = status_q;
        frame_d    = frame_q;
        cnt_d      = cnt_q;
        ferr_d     = 1'b0;
        imem_we    = 1'b0;
        dmem_we    = 1'b0;
        dmem_waddr = frame_q[ADDR_W-1:0];
        dmem_wdata = frame_q[FRAME_W-1:ADDR_W];
        taken      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d  = S_EXEC;
                    pc_d     = '0;
                    cycles_d = '0;
                    status_d = ST_NONE;
                end else if (!cs_i_n) begin
                    state_d = S_IRECV;
                    cnt_d   = '0;
                end else if (!cs_d_n) begin
                    state_d = S_DRECV;
                    cnt_d   = '0;
                end
            end

            S_IRECV, S_DRECV: begin
                if (!cs_n) begin
                    frame_d = {frame_q[FRAME_W-2:0], mosi_i};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = S_IDLE;
                    if (cnt_q == CNT_FULL) begin
                        imem_we = (state_q == S_IRECV);
                        dmem_we = (state_q == S_DRECV);
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end

            S_EXEC: begin
                if (!run_i) begin
                    state_d  = S_IDLE;
                    pc_d     = '0;
                    status_d = ST_ABORT;
                end else if (wdog_hit) begin
                    state_d  = S_IDLE;
                    pc_d     = '0;
                    status_d = ST_WDOG;
                end else begin
                    if (cycles_q != 16'hFFFF) begin
                        cycles_d = cycles_q + 16'd1;
                    end
                    unique case (opcode)
                        OP_ADD:  acc_d = acc_q + m_val;
                        OP_SUB:  acc_d = acc_q - m_val;
                        OP_AND:  acc_d = acc_q & m_val;
                        OP_OR:   acc_d = acc_q | m_val;
                        OP_XOR:  acc_d = acc_q ^ m_val;
                        OP_LD:   acc_d = m_val;
                        OP_MULL: acc_d = prod[DATA_W-1:0];
                        OP_ST: begin
                            dmem_we    = 1'b1;
                            dmem_waddr = operand;
                            dmem_wdata = acc_q;
                        end
                        OP_ADDI: acc_d = acc_q + imm;
                        OP_MULH: acc_d = prod[2*DATA_W-1:DATA_W];
                        OP_SHL:  acc_d = acc_q << 1;
                        OP_SRA:  acc_d = DATA_W'($signed(acc_q) >>> 1);
                        OP_LDI:  acc_d = imm;
                        OP_BEQZ: taken = (acc_q == '0);
                        OP_HALT: ;
                        OP_BNEZ: taken = (acc_q != '0);
                    endcase

                    if (opcode == OP_HALT) begin
                        state_d  = S_IDLE;
                        pc_d     = '0;
                        status_d = ST_HALT;
                    end else if (taken) begin
                        // a taken branch keeps running even from the last slot
                        pc_d = operand;
                    end else if (pc_q == LAST_PC) begin
                        state_d  = S_IDLE;
                        pc_d     = '0;
                        status_d = ST_END;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            acc_q    <= '0;
            cycles_q <= '0;
            status_q <= ST_NONE;
            frame_q  <= '0;
            cnt_q    <= '0;
            ferr_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                imem_q[i] <= '0;
                dmem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            cycles_q <= cycles_d;
            status_q <= status_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            ferr_q   <= ferr_d;
            if (imem_we) begin
                // imem keeps only the low INST_W bits of the data field
                imem_q[frame_q[ADDR_W-1:0]] <= frame_q[ADDR_W +: INST_W];
            end
            if (dmem_we) begin
                dmem_q[dmem_waddr] <= dmem_wdata;
            end
        end
    end

    assign done_o      = (state_q == S_IDLE);
    assign status_o    = status_q;
    assign cycles_o    = cycles_q;
    assign frame_err_o = ferr_q;
    assign acc_o       = acc_q;
    assign dbg_data_o  = dbg_sel_i ? DATA_W'(imem_q[dbg_addr_i])
                                   : dmem_q[dbg_addr_i];

endmodule

// File: tb/tb_acc_proc_core.sv
// tb_acc_proc_core: directed self-checking bench for acc_proc_core
// (DATA_W=8, ADDR_W=4), loading programs serially and checking results.
module tb_acc_proc_core;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int FRAME_W = DATA_W + ADDR_W;

    logic              clk;
    logic              rst;
    logic              run_i;
    logic              cs_i_n;
    logic              cs_d_n;
    logic              mosi_i;
    logic              done_o;
    logic [2:0]        status_o;
    logic [15:0]       cycles_o;
    logic              frame_err_o;
    logic [DATA_W-1:0] acc_o;
    logic              dbg_sel_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_data_o;

    int n_pass;
    int n_total;

    acc_proc_core #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .WDOG_CYCLES(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run_i(run_i),
        .cs_i_n(cs_i_n),
        .cs_d_n(cs_d_n),
        .mosi_i(mosi_i),
        .done_o(done_o),
        .status_o(status_o),
        .cycles_o(cycles_o),
        .frame_err_o(frame_err_o),
        .acc_o(acc_o),
        .dbg_sel_i(dbg_sel_i),
        .dbg_addr_i(dbg_addr_i),
        .dbg_data_o(dbg_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic peek(input string tag, input logic sel,
                        input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] exp);
        dbg_sel_i  = sel;
        dbg_addr_i = addr;
        #1;
        check(tag, 32'(dbg_data_o), 32'(exp));
    endtask

    // Send the top nbits of {data, addr}; cs is dropped one cycle early
    // so the IDLE->RECV transition sees it before the first bit.
    task automatic load(input logic is_d, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input int nbits);
        logic [FRAME_W-1:0] fr;
        fr = {data, addr};
        if (is_d) cs_d_n = 1'b0;
        else      cs_i_n = 1'b0;
        tick();
        for (int i = 0; i < nbits; i++) begin
            mosi_i = fr[FRAME_W-1-i];
            tick();
        end
        cs_i_n = 1'b1;
        cs_d_n = 1'b1;
        tick();
    endtask

    task automatic run_prog(input int bound, output logic timed_out);
        timed_out = 1'b1;
        run_i = 1'b1;
        tick();
        for (int n = 0; n < bound; n++) begin
            if (done_o) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        run_i = 1'b0;
    endtask

    logic to;

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        run_i      = 1'b0;
        cs_i_n     = 1'b1;
        cs_d_n     = 1'b1;
        mosi_i     = 1'b0;
        dbg_sel_i  = 1'b0;
        dbg_addr_i = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_done", 32'(done_o), 32'h1);
        check("rst_status", 32'(status_o), 32'h0);
        check("rst_cycles", 32'(cycles_o), 32'h0);
        check("rst_acc", 32'(acc_o), 32'h0);
        check("rst_ferr", 32'(frame_err_o), 32'h0);
        peek("rst_imem0", 1'b1, 4'd0, 8'h00);

        // LDI 3 ; ST [2] ; HALT
        load(1'b0, 4'd0, 8'h3C, FRAME_W);
        load(1'b0, 4'd1, 8'h27, FRAME_W);
        load(1'b0, 4'd2, 8'h0E, FRAME_W);
        check("ld_done", 32'(done_o), 32'h1);
        check("ld_ferr", 32'(frame_err_o), 32'h0);
        peek("p1_imem1", 1'b1, 4'd1, 8'h27);
        run_prog(50, to);
        check("p1_timeout", 32'(to), 32'h0);
        check("p1_status", 32'(status_o), 32'h2);
        check("p1_cycles", 32'(cycles_o), 32'd3);
        check("p1_acc", 32'(acc_o), 32'h03);
        peek("p1_dmem2", 1'b0, 4'd2, 8'h03);

        // LDI 3 ; ADDI -1 ; BNEZ 1 ; HALT
        load(1'b0, 4'd0, 8'h3C, FRAME_W);
        load(1'b0, 4'd1, 8'hF8, FRAME_W);
        load(1'b0, 4'd2, 8'h1F, FRAME_W);
        load(1'b0, 4'd3, 8'h0E, FRAME_W);
        run_prog(50, to);
        check("p2_timeout", 32'(to), 32'h0);
        check("p2_acc", 32'(acc_o), 32'h00);
        check("p2_status", 32'(status_o), 32'h2);
        check("p2_cycles", 32'(cycles_o), 32'd8);

        // short 11-bit frame is rejected
        load(1'b0, 4'd0, 8'h55, FRAME_W - 1);
        check("ferr_pulse", 32'(frame_err_o), 32'h1);
        check("ferr_done", 32'(done_o), 32'h1);
        tick();
        check("ferr_clear", 32'(frame_err_o), 32'h0);
        peek("ferr_imem0", 1'b1, 4'd0, 8'h3C);

        // LD [0] ; MULL [1] ; ST [2] ; LD [0] ; MULH [1] ; HALT
        load(1'b1, 4'd0, 8'hFE, FRAME_W);
        load(1'b1, 4'd1, 8'h05, FRAME_W);
        peek("p3_dmem0", 1'b0, 4'd0, 8'hFE);
        load(1'b0, 4'd0, 8'h05, FRAME_W);
        load(1'b0, 4'd1, 8'h16, FRAME_W);
        load(1'b0, 4'd2, 8'h27, FRAME_W);
        load(1'b0, 4'd3, 8'h05, FRAME_W);
        load(1'b0, 4'd4, 8'h19, FRAME_W);
        load(1'b0, 4'd5, 8'h0E, FRAME_W);
        run_prog(50, to);
        check("p3_timeout", 32'(to), 32'h0);
        peek("p3_dmem2", 1'b0, 4'd2, 8'hF6);
        check("p3_acc", 32'(acc_o), 32'hFF);
        check("p3_status", 32'(status_o), 32'h2);
        check("p3_cycles", 32'(cycles_o), 32'd6);

        // LDI 1 ; BNEZ 1  (endless loop)
        load(1'b0, 4'd0, 8'h1C, FRAME_W);
        load(1'b0, 4'd1, 8'h1F, FRAME_W);
`ifdef ACC_PROC_WDOG_EN
        run_prog(400, to);
        check("wd_timeout", 32'(to), 32'h0);
        check("wd_status", 32'(status_o), 32'h4);
        check("wd_cycles", 32'(cycles_o), 32'd255);
        check("wd_acc", 32'(acc_o), 32'h01);
`else
        run_i = 1'b1;
        tick();
        for (int n = 0; n < 20; n++) tick();
        check("ab_busy", 32'(done_o), 32'h0);
        check("ab_status_run", 32'(status_o), 32'h0);
        run_i = 1'b0;
        tick();
        check("ab_done", 32'(done_o), 32'h1);
        check("ab_status", 32'(status_o), 32'h3);
        check("ab_cycles", 32'(cycles_o), 32'd20);
        check("ab_acc", 32'(acc_o), 32'h01);
`endif

        // reset clears imem: sixteen ADD [0] then END at the last slot
        rst = 1'b1;
        tick();
        rst = 1'b0;
        peek("clr_imem1", 1'b1, 4'd1, 8'h00);
        load(1'b1, 4'd0, 8'h01, FRAME_W);
        run_prog(50, to);
        check("end_timeout", 32'(to), 32'h0);
        check("end_status", 32'(status_o), 32'h1);
        check("end_cycles", 32'(cycles_o), 32'd16);
        check("end_acc", 32'(acc_o), 32'h10);
        tick();
        tick();
        check("end_hold", 32'(status_o), 32'h1);

        // reset in the middle of a run
        load(1'b0, 4'd0, 8'h1C, FRAME_W);
        load(1'b0, 4'd1, 8'h1F, FRAME_W);
        run_i = 1'b1;
        tick();
        for (int n = 0; n < 5; n++) tick();
        check("mr_busy", 32'(done_o), 32'h0);
        rst   = 1'b1;
        run_i = 1'b0;
        tick();
        rst = 1'b0;
        check("mr_done", 32'(done_o), 32'h1);
        check("mr_status", 32'(status_o), 32'h0);
        check("mr_cycles", 32'(cycles_o), 32'h0);
        check("mr_acc", 32'(acc_o), 32'h0);
        peek("mr_imem0", 1'b1, 4'd0, 8'h00);
        peek("mr_dmem0", 1'b0, 4'd0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
